// File: rtl/id_ex_if.sv
// Signal bundle between the ID/hazard side and the ID/EX pipeline register.
// The master drives ID-stage values and selects; the slave (the register) drives the EX-stage outputs.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic [1:0]        MUX_PA_E;
  logic [1:0]        MUX_PB_E;
  logic              CUMUX_E;
  logic              FLUSH;
  logic [DATA_W-1:0] ID_PA;
  logic [DATA_W-1:0] ID_PB;
  logic [DATA_W-1:0] EX_ALU_OUT;
  logic [DATA_W-1:0] MEM_OUT;
  logic [DATA_W-1:0] WB_PW;
  logic [DATA_W-1:0] ID_PC;
  logic [DATA_W-1:0] ID_IMM;
  logic [4:0]        ID_RD;
  logic [CTRL_W-1:0] ID_CTRL;

  logic [DATA_W-1:0] EX_PA;
  logic [DATA_W-1:0] EX_PB;
  logic [DATA_W-1:0] EX_PC;
  logic [DATA_W-1:0] EX_IMM;
  logic [4:0]        EX_RD;
  logic [CTRL_W-1:0] EX_CTRL;
  logic              EX_VALID;
  logic              EX_RF_E;
  logic              EX_LOAD;
  logic [CNT_W-1:0]  BUBBLE_CNT;
  logic [CNT_W-1:0]  FLUSH_CNT;

  modport master (
    output MUX_PA_E, MUX_PB_E, CUMUX_E, FLUSH,
    output ID_PA, ID_PB, EX_ALU_OUT, MEM_OUT, WB_PW, ID_PC, ID_IMM, ID_RD, ID_CTRL,
    input  EX_PA, EX_PB, EX_PC, EX_IMM, EX_RD, EX_CTRL, EX_VALID, EX_RF_E, EX_LOAD,
    input  BUBBLE_CNT, FLUSH_CNT
  );

  modport slave (
    input  MUX_PA_E, MUX_PB_E, CUMUX_E, FLUSH,
    input  ID_PA, ID_PB, EX_ALU_OUT, MEM_OUT, WB_PW, ID_PC, ID_IMM, ID_RD, ID_CTRL,
    output EX_PA, EX_PB, EX_PC, EX_IMM, EX_RD, EX_CTRL, EX_VALID, EX_RF_E, EX_LOAD,
    output BUBBLE_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with operand forwarding muxes, bubble/flush squashing
// and saturating bubble/flush event counters.
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic [CNT_W-1:0]  bubble_cnt_nxt_s;
  logic [CNT_W-1:0]  flush_cnt_nxt_s;

  logic [DATA_W-1:0] ex_pa_r;
  logic [DATA_W-1:0] ex_pb_r;
  logic [DATA_W-1:0] ex_pc_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic [4:0]        ex_rd_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic              ex_valid_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  // Forwarding mux for operand A
  always_comb begin
    op_a_s = bus.ID_PA;
    case (bus.MUX_PA_E)
      2'b00:   op_a_s = bus.ID_PA;
      2'b01:   op_a_s = bus.EX_ALU_OUT;
      2'b10:   op_a_s = bus.MEM_OUT;
      2'b11:   op_a_s = bus.WB_PW;
      default: op_a_s = bus.ID_PA;
    endcase
  end

  // Forwarding mux for operand B
  always_comb begin
    op_b_s = bus.ID_PB;
    case (bus.MUX_PB_E)
      2'b00:   op_b_s = bus.ID_PB;
      2'b01:   op_b_s = bus.EX_ALU_OUT;
      2'b10:   op_b_s = bus.MEM_OUT;
      2'b11:   op_b_s = bus.WB_PW;
      default: op_b_s = bus.ID_PB;
    endcase
  end

  // Saturating next-count values; flush takes precedence so a bubble under flush is not counted
  always_comb begin
    bubble_cnt_nxt_s = bubble_cnt_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    if (bus.FLUSH) begin
      if (flush_cnt_r != CNT_MAX) begin
        flush_cnt_nxt_s = flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_nxt_s = flush_cnt_r;
      end
    end else if (bus.CUMUX_E) begin
      if (bubble_cnt_r != CNT_MAX) begin
        bubble_cnt_nxt_s = bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bubble_cnt_nxt_s = bubble_cnt_r;
      end
    end else begin
      bubble_cnt_nxt_s = bubble_cnt_r;
      flush_cnt_nxt_s  = flush_cnt_r;
    end
  end

  // Pipeline register: reset > flush > bubble > normal load, every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pa_r      <= {DATA_W{1'b0}};
      ex_pb_r      <= {DATA_W{1'b0}};
      ex_pc_r      <= {DATA_W{1'b0}};
      ex_imm_r     <= {DATA_W{1'b0}};
      ex_rd_r      <= 5'd0;
      ex_ctrl_r    <= {CTRL_W{1'b0}};
      ex_valid_r   <= 1'b0;
      bubble_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      bubble_cnt_r <= bubble_cnt_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
      if (bus.FLUSH) begin
        ex_pa_r    <= {DATA_W{1'b0}};
        ex_pb_r    <= {DATA_W{1'b0}};
        ex_pc_r    <= {DATA_W{1'b0}};
        ex_imm_r   <= {DATA_W{1'b0}};
        ex_rd_r    <= 5'd0;
        ex_ctrl_r  <= {CTRL_W{1'b0}};
        ex_valid_r <= 1'b0;
      end else if (bus.CUMUX_E) begin
        // Bubble keeps the datapath flowing but kills every side effect
        ex_pa_r    <= op_a_s;
        ex_pb_r    <= op_b_s;
        ex_pc_r    <= bus.ID_PC;
        ex_imm_r   <= bus.ID_IMM;
        ex_rd_r    <= 5'd0;
        ex_ctrl_r  <= {CTRL_W{1'b0}};
        ex_valid_r <= 1'b0;
      end else begin
        ex_pa_r    <= op_a_s;
        ex_pb_r    <= op_b_s;
        ex_pc_r    <= bus.ID_PC;
        ex_imm_r   <= bus.ID_IMM;
        ex_rd_r    <= bus.ID_RD;
        ex_ctrl_r  <= bus.ID_CTRL;
        ex_valid_r <= 1'b1;
      end
    end
  end

  assign bus.EX_PA      = ex_pa_r;
  assign bus.EX_PB      = ex_pb_r;
  assign bus.EX_PC      = ex_pc_r;
  assign bus.EX_IMM     = ex_imm_r;
  assign bus.EX_RD      = ex_rd_r;
  assign bus.EX_CTRL    = ex_ctrl_r;
  assign bus.EX_VALID   = ex_valid_r;
  assign bus.EX_RF_E    = ex_ctrl_r[0];
  assign bus.EX_LOAD    = ex_ctrl_r[1];
  assign bus.BUBBLE_CNT = bubble_cnt_r;
  assign bus.FLUSH_CNT  = flush_cnt_r;

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32, width of operand, PC and immediate datapaths.
REQ-002 Parameter CTRL_W, default 16, width of control bundle; bit0 = RF_E, bit1 = load, bit2 = mem write, others opaque.
REQ-003 Parameter CNT_W, default 16, width of bubble/flush event counters.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MUX_PA_E  input  2  operand-A source select from hazard/forwarding unit.
REQ-007 MUX_PB_E  input  2  operand-B source select from hazard/forwarding unit.
REQ-008 CUMUX_E  input  1  load-use stall; insert bubble into EX.
REQ-009 FLUSH  input  1  taken branch/jump resolved; squash ID instruction.
REQ-010 ID_PA, ID_PB  input  DATA_W each  register-file read ports.
REQ-011 EX_ALU_OUT, MEM_OUT, WB_PW  input  DATA_W each  forwarding sources from EX, MEM, WB.
REQ-012 ID_PC, ID_IMM  input  DATA_W each  decoded PC and immediate.
REQ-013 ID_RD  input  5  destination register; ID_CTRL  input  CTRL_W  decoded control bundle.
REQ-014 EX_PA, EX_PB, EX_PC, EX_IMM  output  DATA_W each  registered operands/PC/immediate.
REQ-015 EX_RD  output  5; EX_CTRL  output  CTRL_W; EX_VALID  output  1.
REQ-016 EX_RF_E, EX_LOAD  output  1 each  EX_CTRL[0], EX_CTRL[1] fed back to hazard unit (combinational from registers).
REQ-017 BUBBLE_CNT, FLUSH_CNT  output  CNT_W each  event counters.

Function
REQ-018 Operand select (combinational, both A and B): 00 = ID_Px, 01 = EX_ALU_OUT, 10 = MEM_OUT, 11 = WB_PW.
REQ-019 Latency exactly one clk: values selected in cycle N appear on outputs after edge N.
REQ-020 Per-edge priority: reset > FLUSH > CUMUX_E > normal load.
REQ-021 Normal (FLUSH=0, CUMUX_E=0): load selected operands, ID_PC, ID_IMM, ID_RD, ID_CTRL; EX_VALID=1.
REQ-022 Bubble (CUMUX_E=1, FLUSH=0): EX_CTRL=0, EX_RD=0, EX_VALID=0; EX_PA/PB/PC/IMM load normally; BUBBLE_CNT increments.
REQ-023 Flush (FLUSH=1, any CUMUX_E): all outputs registers set to 0, EX_VALID=0; FLUSH_CNT increments; BUBBLE_CNT unchanged.
REQ-024 Counters saturate at 2^CNT_W-1; no wrap to zero.
REQ-025 No stall-hold mode: register loads every cycle; hold of ID is upstream responsibility.
REQ-026 No internal combinational path from MUX_Px_E/CUMUX_E/FLUSH to any output.

Reset
REQ-027 While reset=1, asynchronously and immediately: all data outputs 0, EX_CTRL=0, EX_RD=0, EX_VALID=0, both counters 0.
REQ-028 Reset asserted mid-operation overrides any pending bubble/flush; first edge after deassertion performs normal priority evaluation.

Verification
REQ-029 Normal: ID_PA=0x11, MUX_PA_E=00, ID_RD=5, ID_CTRL=0x0001 -> next edge EX_PA=0x11, EX_RD=5, EX_RF_E=1, EX_VALID=1.
REQ-030 Forwarding: EX_ALU_OUT=0xA, MEM_OUT=0xB, WB_PW=0xC; sweep MUX_PA_E/MUX_PB_E 01,10,11 -> EX_PA/EX_PB = 0xA, 0xB, 0xC respectively.
REQ-031 Bubble: CUMUX_E=1, ID_CTRL=0x0003, ID_RD=7 -> EX_CTRL=0, EX_RD=0, EX_VALID=0, BUBBLE_CNT 0->1.
REQ-032 Simultaneous: FLUSH=1, CUMUX_E=1 -> all outputs 0, FLUSH_CNT=1, BUBBLE_CNT unchanged.
REQ-033 Saturation: CNT_W=4, 20 consecutive bubbles -> BUBBLE_CNT holds 0xF.
REQ-034 Async reset: assert reset between edges with EX_VALID=1 -> outputs and counters 0 before next edge; deassert, normal load resumes next edge.
